// File: rtl/piso_shreg.sv
// -----------------------------------------------------------------------------
// piso_shreg - parallel-in / serial-out shift register
//
// Captures a WIDTH-bit word on a valid/ready handshake, then shifts it out
// LSB first, one bit per en_i tick. An optional even-parity bit can follow
// the data bits.
//
// Build option:
//   PISO_PARITY_EN  when defined, a PARITY state follows SHIFT and WIDTH+1
//                   serial bits are sent per word; when undefined, WIDTH
//                   bits are sent and no parity logic exists.
//
// Parameters:
//   WIDTH        data word width in bits (2..16)
//
// Ports:
//   clk_i        in   clock, rising edge
//   rst_ni       in   asynchronous active-low reset
//   data_i       in   parallel word to serialise
//   valid_i      in   data_i valid
//   ready_o      out  block can accept a word (IDLE)
//   en_i         in   shift tick, advances the serial stream by one bit
//   ser_o        out  serial data
//   ser_valid_o  out  ser_o carries a valid bit
//   done_o       out  one-cycle pulse after the last serial bit is consumed
// -----------------------------------------------------------------------------
module piso_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             en_i,
    output logic             ser_o,
    output logic             ser_valid_o,
    output logic             done_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

`ifdef PISO_PARITY_EN
    // Even parity of a word (XOR reduction).
    function automatic logic parity_even(input logic [WIDTH-1:0] word);
        parity_even = ^word;
    endfunction
`endif

    // Serial merge cell: 2:1 mux gated by an active qualifier.
    function automatic logic mux2_ands(input logic i0, input logic i1,
                                       input logic sel, input logic act);
        mux2_ands = (sel ? i1 : i0) & act;
    endfunction

    state_t             state_r, state_s;
    logic [WIDTH-1:0]   shreg_r, shreg_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               done_r, done_s;
    logic               active_s;
    logic               in_parity_s;
    logic               par_bit_s;

`ifdef PISO_PARITY_EN
    logic               parity_r, parity_s;
`endif

    // State, datapath and done pulse registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r  <= ST_IDLE;
            shreg_r  <= {WIDTH{1'b0}};
            cnt_r    <= CNT_ZERO;
            done_r   <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_r <= 1'b0;
`endif
        end else begin
            state_r  <= state_s;
            shreg_r  <= shreg_s;
            cnt_r    <= cnt_s;
            done_r   <= done_s;
`ifdef PISO_PARITY_EN
            parity_r <= parity_s;
`endif
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_s  = state_r;
        shreg_s  = shreg_r;
        cnt_s    = cnt_r;
        done_s   = 1'b0;
`ifdef PISO_PARITY_EN
        parity_s = parity_r;
`endif
        case (state_r)
            ST_IDLE: begin
                // en_i is ignored here, so a simultaneous capture always wins.
                if (valid_i) begin
                    shreg_s  = data_i;
                    cnt_s    = CNT_ZERO;
                    state_s  = ST_SHIFT;
`ifdef PISO_PARITY_EN
                    parity_s = parity_even(data_i);
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (en_i) begin
                    shreg_s = {1'b0, shreg_r[WIDTH-1:1]};
                    cnt_s   = cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
`ifdef PISO_PARITY_EN
                        state_s = ST_PARITY;
`else
                        state_s = ST_IDLE;
                        done_s  = 1'b1;
`endif
                    end else begin
                        state_s = ST_SHIFT;
                    end
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_PARITY: begin
`ifdef PISO_PARITY_EN
                if (en_i) begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_PARITY;
                end
`else
                state_s = ST_IDLE;
`endif
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode straight from state flops; no input-to-output paths.
    assign active_s = (state_r == ST_SHIFT) || (state_r == ST_PARITY);

`ifdef PISO_PARITY_EN
    assign in_parity_s = (state_r == ST_PARITY);
    assign par_bit_s   = parity_r;
`else
    assign in_parity_s = 1'b0;
    assign par_bit_s   = 1'b0;
`endif

    assign ready_o     = (state_r == ST_IDLE);
    assign ser_valid_o = active_s;
    assign ser_o       = mux2_ands(shreg_r[0], par_bit_s, in_parity_s, active_s);
    assign done_o      = done_r;

endmodule
